// File: rtl/rv_mux_pkg.sv
// rv_mux_pkg: shared sizing helpers and types for the round-robin select mux.
package rv_mux_pkg;
    localparam int MAX_CH = 16;
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    typedef logic [ch_w(MAX_CH)-1:0] grant_idx_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant search upward from i_ptr with wrap.
// With RR_SEL_MUX_FIXED_PRIO_EN defined, i_ptr is removed and channel 0 always has top priority.
module rr_arbiter
    import rv_mux_pkg::*;
#(
    parameter int NUM_CH = 5,
    localparam int CH_W = ch_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
`ifndef RR_SEL_MUX_FIXED_PRIO_EN
    input  logic [CH_W-1:0]   i_ptr,
`endif
    output logic [NUM_CH-1:0] o_gnt,
    output logic [CH_W-1:0]   o_idx,
    output logic              o_any
);
    logic [CH_W-1:0] w_base;
`ifdef RR_SEL_MUX_FIXED_PRIO_EN
    assign w_base = '0;
`else
    assign w_base = i_ptr;
`endif
    assign o_any = |i_req;
    // Walk offsets from the far end down so the nearest requester above the base wins.
    always_comb begin
        int j;
        j = 0;
        o_gnt = '0;
        o_idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            j = int'(w_base) + k;
            j = (j >= NUM_CH) ? j - NUM_CH : j;
            if (i_req[j]) begin
                o_gnt = '0;
                o_gnt[j] = 1'b1;
                o_idx = CH_W'(j);
            end
        end
    end
endmodule

// File: rtl/rr_sel_mux.sv
// rr_sel_mux: N-way round-robin select mux with one registered valid/ready output stage.
// Define RR_SEL_MUX_FIXED_PRIO_EN for lowest-index-wins arbitration without rr_ptr.
module rr_sel_mux
    import rv_mux_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_CH = 5,
    localparam int CH_W = ch_w(NUM_CH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          in_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]          in_ready,
    output logic                       out_valid,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [CH_W-1:0]            out_ch,
    input  logic                       out_ready
);
    logic [NUM_CH-1:0]     w_gnt;
    logic [CH_W-1:0]       w_idx;
    logic                  w_any;
    logic                  w_load;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic [CH_W-1:0]       r_ch;
`ifndef RR_SEL_MUX_FIXED_PRIO_EN
    logic [CH_W-1:0]       r_ptr;
`endif

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .i_req (in_valid),
`ifndef RR_SEL_MUX_FIXED_PRIO_EN
        .i_ptr (r_ptr),
`endif
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // rst_n gating keeps in_ready low while the block is held in reset.
    assign w_load    = rst_n && w_any && (!r_valid || out_ready);
    assign in_ready  = w_gnt & {NUM_CH{w_load}};
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_ch    = r_ch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ch    <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= in_data[w_idx*DATA_WIDTH +: DATA_WIDTH];
            r_ch    <= w_idx;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

`ifndef RR_SEL_MUX_FIXED_PRIO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ptr <= '0;
        else if (w_load)
            r_ptr <= (w_idx == CH_W'(NUM_CH - 1)) ? '0 : w_idx + CH_W'(1);
    end
`endif
endmodule

// File: tb/tb_rr_sel_mux.sv
// tb_rr_sel_mux: directed scoreboard bench for rr_sel_mux (5 channels, 64-bit payloads).
module tb_rr_sel_mux;
    localparam int DW = 64;
    localparam int NC = 5;

    typedef struct {
        logic [2:0]  ch;
        logic [63:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NC-1:0]   in_valid;
    logic [NC*DW-1:0] in_data;
    logic [NC-1:0]   in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [2:0]      out_ch;
    logic            out_ready;

    exp_t q[$];
    int   n_pass = 0;
    int   n_total = 0;

    rr_sel_mux #(.DATA_WIDTH(DW), .NUM_CH(NC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pl(input int ch, input logic [15:0] tag);
        return {32'hDEAD_BEEF, tag, 16'(ch)};
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    endtask

    // Unrequested lanes carry X so any leak into out_data is visible.
    task automatic drive(input logic [NC-1:0] v, input logic [15:0] tag);
        in_valid = v;
        for (int i = 0; i < NC; i++)
            in_data[i*DW +: DW] = v[i] ? pl(i, tag) : {DW{1'bx}};
    endtask

    task automatic beat(input logic [NC-1:0] v, input logic [15:0] tag, input int exp_ch);
        exp_t e;
        drive(v, tag);
        #1;
        chk("in_ready_onehot", 64'(in_ready), 64'(NC'(1) << exp_ch));
        e.ch = 3'(exp_ch);
        e.data = pl(exp_ch, tag);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("sb_underflow", 64'(q.size()), 64'd1);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_ch", 64'(out_ch), 64'(e.ch));
                chk("sb_data", out_data, e.data);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        out_ready = 1'b1;
        drive(5'h1f, 16'h1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_ch", 64'(out_ch), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("first_latency_valid", 64'(out_valid), 64'd0);
        #1;
        for (int i = 0; i < 10; i++) begin
            beat(5'h1f, 16'h1, i % NC);
            chk("rr_back_to_back", 64'(out_valid), 64'd1);
        end
        for (int i = 0; i < 4; i++)
            beat(5'b10010, 16'h2, (i % 2 == 0) ? 1 : 4);
        beat(5'b01100, 16'h0, 2);
        out_ready = 1'b0;
        drive(5'b01000, 16'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_data", out_data, 64'hDEAD_BEEF_0000_0002);
            chk("stall_ch", 64'(out_ch), 64'd2);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        beat(5'b01000, 16'h0, 3);
        chk("no_bubble_valid", 64'(out_valid), 64'd1);
        chk("no_bubble_ch", 64'(out_ch), 64'd3);
        beat(5'b00001, 16'h5, 0);
        drive(5'b00000, 16'h0);
        @(posedge clk);
        #1;
        chk("drain_valid", 64'(out_valid), 64'd0);
        chk("drain_data_hold", out_data, pl(0, 16'h5));
        chk("drain_ch_hold", 64'(out_ch), 64'd0);
        @(posedge clk);
        #1;
        chk("idle_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b0;
        beat(5'h1f, 16'h6, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_data", out_data, 64'd0);
        chk("async_rst_ch", 64'(out_ch), 64'd0);
        chk("async_rst_in_ready", 64'(in_ready), 64'd0);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        beat(5'b01010, 16'h7, 1);
        for (int i = 0; i < 4; i++) begin
`ifdef RR_SEL_MUX_FIXED_PRIO_EN
            beat(5'b01001, 16'h8, 0);
`else
            beat(5'b01001, 16'h8, (i % 2 == 0) ? 3 : 0);
`endif
        end
        drive(5'b00000, 16'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("final_idle_valid", 64'(out_valid), 64'd0);
        chk("sb_leftover", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/rr_sel_mux.md
Name: rr_sel_mux

Overview:
- Parametrised N-way round-robin selecting multiplexer with one registered output stage and valid/ready handshakes on every channel.
- Successor to the fixed 5-input combinational select mux. Channel choice comes from internal arbitration, not an external select, and the result is held until the consumer accepts it.
- Used where several pipeline producers share one consumer port, e.g. writeback or LSU response merge.

Parameters:
- DATA_WIDTH, 64, payload width per channel in bits.
- NUM_CH, 5, number of input channels (legal range 2..16; need not be a power of two).
- CH_W, (NUM_CH>1 ? $clog2(NUM_CH) : 1), width of the channel index. Localparam; not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  NUM_CH  per-channel request valid.
- in_data  in  NUM_CH*DATA_WIDTH  flattened payloads; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_ready  out  NUM_CH  per-channel accept. One-hot or zero; combinational.
- out_valid  out  1  registered output valid.
- out_data  out  DATA_WIDTH  registered selected payload.
- out_ch  out  CH_W  registered index of the channel that produced out_data.
- out_ready  in  1  consumer accept.

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_data=0, out_ch=0, rr_ptr=0. in_ready is 0 while rst_n=0.
- load = (|in_valid) && (!out_valid || out_ready).
- Grant, round-robin: the first channel with in_valid set, searching upward from rr_ptr and wrapping from NUM_CH-1 to 0.
- Grant is combinational. in_ready[g]=load for the granted channel g only; all other bits are 0.
- On clk edge with load:
  - out_data <= payload of channel g.
  - out_ch <= g.
  - out_valid <= 1.
  - rr_ptr <= (g==NUM_CH-1) ? 0 : g+1.
- On clk edge with out_valid && out_ready && !(|in_valid): out_valid <= 0. out_data and out_ch hold their old values.
- Stall (out_valid && !out_ready): out_valid, out_data, out_ch and rr_ptr are all stable, and in_ready is all zero. A producer holds in_valid/in_data until its in_ready is high.
- Latency and throughput: input-to-output latency is 1 cycle. Full throughput of 1 transfer/cycle is sustained when out_ready=1. A simultaneous drain and refill in the same cycle keeps out_valid=1 with no bubble.
- Fairness: under continuous requests on k channels, each channel is granted once every k transfers. No channel waits more than NUM_CH-1 grants.
- rr_ptr changes only on a load, never while idle or stalled.
- Non-power-of-two NUM_CH: the pointer never takes a value >= NUM_CH.
- Reset mid-transfer: a held output is dropped without handshake and arbitration restarts at channel 0.
- in_data of channels without in_valid is ignored. X on those lanes must not propagate to out_data.

Optional Feature:
- Macro RR_SEL_MUX_FIXED_PRIO_EN.
- Defined: fixed priority arbitration, where the lowest-indexed valid channel always wins. rr_ptr is not implemented (removed, no flops). This matches the legacy priority of the original select mux.
- Undefined (default): round-robin as specified above.
- Handshake, latency and reset behaviour are identical in both builds.

Decomposition:
- Shared package rv_mux_pkg holds:
  - the CH_W sizing function (clog2 with minimum of 1);
  - a localparam for the maximum NUM_CH (16);
  - the grant-index typedef, so consumers of out_ch share the width.
- One sub-module, rr_arbiter: takes request vector and pointer, returns one-hot grant, encoded index and any-valid.
  - The fixed-priority variant is selected inside rr_arbiter under the macro.
  - rr_sel_mux keeps the output register, the handshake and rr_ptr.

Test Plan:
- Reset: rst_n low mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_ch=0 immediately (asynchronous). The first grant after release goes to the lowest valid channel at or above index 0.
- Round-robin: all 5 channels valid continuously, out_ready=1, payload = channel index -> out_ch sequence 0,1,2,3,4,0,1. One beat per cycle, starting 1 cycle after the first valid.
- Wrap and sparse: only channels 1 and 4 valid after a grant of 4 -> next grants 1,4,1,4. rr_ptr never reaches 5.
- Backpressure: out_ready=0 for 3 cycles with out_data=0xDEAD_BEEF_0000_0002, out_ch=2 -> output stable and in_ready=0 throughout. Release -> next grant is channel 3 in the same cycle as the drain, with no bubble.
- Drain to idle: single request on channel 0, then in_valid=0 with out_ready=1 -> out_valid drops the cycle after acceptance and out_data holds.
- Build with RR_SEL_MUX_FIXED_PRIO_EN: channels 0 and 3 valid continuously -> channel 0 granted every cycle and channel 3 starves, as required for fixed priority.
